// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter for a shared single-port memory. It keeps one
// transaction outstanding, grants combinationally from IDLE and returns rvalid after MEM_LAT cycles.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  localparam int unsigned CW = 4;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_d, last_d_nxt;   // 1: data side granted last, and owns the WAIT transaction
  logic          we_q, we_nxt;
  logic          gnt_i, gnt_d, done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      last_d <= 1'b0;
      we_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      last_d <= last_d_nxt;
      we_q   <= we_nxt;
    end
  end

  // Arbitration, latency counting and output decode; everything is forced low while rst is high.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_d_nxt = last_d;
    we_nxt     = we_q;
    gnt_i      = 1'b0;
    gnt_d      = 1'b0;
    done       = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (d_req && (!i_req || !last_d)) gnt_d = 1'b1;
          else if (i_req)                   gnt_i = 1'b1;
          if (gnt_i || gnt_d) begin
            state_nxt  = WAIT;
            cnt_nxt    = CW'(MEM_LAT - 1);
            last_d_nxt = gnt_d;
            we_nxt     = gnt_d & d_we;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    i_gnt     = gnt_i;
    d_gnt     = gnt_d;
    mem_req   = gnt_i | gnt_d;
    mem_we    = gnt_d & d_we;
    mem_addr  = gnt_d ? d_addr : (gnt_i ? i_addr : '0);
    mem_wdata = gnt_d ? d_wdata : '0;
    i_rvalid  = done & ~last_d;
    d_rvalid  = done & last_d;
    i_rdata   = i_rvalid ? mem_rdata : '0;
    d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;
    busy      = !rst && (state == WAIT);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=3 share
// the same stimulus; each scenario resets both and checks the instance of interest.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;

  logic        i_gnt_1, i_rvalid_1, d_gnt_1, d_rvalid_1, mem_req_1, mem_we_1, busy_1;
  logic [31:0] i_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1;
  logic        i_gnt_3, i_rvalid_3, d_gnt_3, d_rvalid_3, mem_req_3, mem_we_3, busy_3;
  logic [31:0] i_rdata_3, d_rdata_3, mem_addr_3, mem_wdata_3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(1), .AW(32)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_1), .i_rvalid(i_rvalid_1), .i_rdata(i_rdata_1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_1), .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1),
    .mem_req(mem_req_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata), .busy(busy_1)
  );

  mem_arbiter #(.MEM_LAT(3), .AW(32)) u_dut3 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_3), .i_rvalid(i_rvalid_3), .i_rdata(i_rdata_3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_3), .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3),
    .mem_req(mem_req_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata), .busy(busy_3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  logic exp_dg [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic exp_ig [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    // Reset state, including a pending request that must not be granted while rst is high
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    i_addr = 32'h10; d_addr = 32'h20; d_wdata = 32'h5A; mem_rdata = 32'hDEADBEEF;
    mid();
    check("rst_i_gnt", 32'(i_gnt_1), 32'd0);
    check("rst_d_gnt", 32'(d_gnt_1), 32'd0);
    check("rst_mem_req", 32'(mem_req_1), 32'd0);
    check("rst_mem_addr", mem_addr_1, 32'd0);
    check("rst_busy", 32'(busy_1), 32'd0);

    // Single fetch read at MEM_LAT=1
    reset_dut();
    i_req = 1'b1; i_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    mid();
    check("f1_i_gnt", 32'(i_gnt_1), 32'd1);
    check("f1_mem_req", 32'(mem_req_1), 32'd1);
    check("f1_mem_addr", mem_addr_1, 32'h10);
    check("f1_mem_we", 32'(mem_we_1), 32'd0);
    check("f1_mem_wdata", mem_wdata_1, 32'd0);
    check("f1_i_rvalid_c0", 32'(i_rvalid_1), 32'd0);
    check("f1_busy_c0", 32'(busy_1), 32'd0);
    next_cycle();
    i_req = 1'b0;
    mid();
    check("f1_i_rvalid", 32'(i_rvalid_1), 32'd1);
    check("f1_i_rdata", i_rdata_1, 32'hDEADBEEF);
    check("f1_busy_c1", 32'(busy_1), 32'd1);
    check("f1_mem_req_c1", 32'(mem_req_1), 32'd0);
    check("f1_d_rvalid_c1", 32'(d_rvalid_1), 32'd0);
    next_cycle();
    mid();
    check("f1_busy_c2", 32'(busy_1), 32'd0);
    check("f1_i_rvalid_c2", 32'(i_rvalid_1), 32'd0);
    check("f1_i_rdata_c2", i_rdata_1, 32'd0);

    // Both requesting from reset: data first, then alternate, grants two cycles apart
    reset_dut();
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h100; d_addr = 32'h200; mem_rdata = 32'hCAFE0001;
    for (int c = 0; c < 6; c++) begin
      mid();
      check($sformatf("rr_d_gnt_c%0d", c), 32'(d_gnt_1), 32'(exp_dg[c]));
      check($sformatf("rr_i_gnt_c%0d", c), 32'(i_gnt_1), 32'(exp_ig[c]));
      if (c == 0 || c == 4) check($sformatf("rr_addr_c%0d", c), mem_addr_1, 32'h200);
      if (c == 2) check("rr_addr_c2", mem_addr_1, 32'h100);
      if (c == 1) check("rr_d_rdata_c1", d_rdata_1, 32'hCAFE0001);
      if (c == 3) check("rr_i_rvalid_c3", 32'(i_rvalid_1), 32'd1);
      next_cycle();
    end
    i_req = 1'b0; d_req = 1'b0;

    // Data write at MEM_LAT=3
    reset_dut();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h5A; mem_rdata = 32'h12345678;
    mid();
    check("w3_d_gnt", 32'(d_gnt_3), 32'd1);
    check("w3_mem_we", 32'(mem_we_3), 32'd1);
    check("w3_mem_wdata", mem_wdata_3, 32'h5A);
    check("w3_mem_addr", mem_addr_3, 32'h20);
    next_cycle();
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    for (int c = 1; c <= 2; c++) begin
      mid();
      check($sformatf("w3_d_rvalid_c%0d", c), 32'(d_rvalid_3), 32'd0);
      check($sformatf("w3_busy_c%0d", c), 32'(busy_3), 32'd1);
      next_cycle();
    end
    mid();
    check("w3_d_rvalid_c3", 32'(d_rvalid_3), 32'd1);
    check("w3_d_rdata_c3", d_rdata_3, 32'd0);
    next_cycle();
    mid();
    check("w3_busy_c4", 32'(busy_3), 32'd0);
    check("w3_d_rvalid_c4", 32'(d_rvalid_3), 32'd0);

    // Reset in the middle of a MEM_LAT=3 fetch aborts it
    reset_dut();
    i_req = 1'b1; i_addr = 32'h40; mem_rdata = 32'hA5A5A5A5;
    mid();
    check("ab_i_gnt_c0", 32'(i_gnt_3), 32'd1);
    next_cycle();
    i_req = 1'b0;
    mid();
    check("ab_busy_c1", 32'(busy_3), 32'd1);
    next_cycle();
    rst = 1'b1;
    #1;
    check("ab_busy_rst", 32'(busy_3), 32'd0);
    check("ab_i_rvalid_rst", 32'(i_rvalid_3), 32'd0);
    check("ab_mem_req_rst", 32'(mem_req_3), 32'd0);
    next_cycle();
    mid();
    check("ab_i_rvalid_c3", 32'(i_rvalid_3), 32'd0);
    check("ab_i_rdata_c3", i_rdata_3, 32'd0);
    next_cycle();
    rst = 1'b0; i_req = 1'b1; i_addr = 32'h44;
    mid();
    check("ab_regrant", 32'(i_gnt_3), 32'd1);
    check("ab_regrant_addr", mem_addr_3, 32'h44);
    check("ab_i_rvalid_c4", 32'(i_rvalid_3), 32'd0);
    next_cycle();
    i_req = 1'b0;

    // No grants during WAIT: a one-cycle fetch pulse is dropped, a data request waits for IDLE
    reset_dut();
    i_req = 1'b1; i_addr = 32'h80; mem_rdata = 32'h0BADF00D;
    mid();
    check("wt_i_gnt_c0", 32'(i_gnt_3), 32'd1);
    next_cycle();
    i_req = 1'b1; i_addr = 32'h84;
    mid();
    check("wt_pulse_i_gnt", 32'(i_gnt_3), 32'd0);
    check("wt_pulse_mem_req", 32'(mem_req_3), 32'd0);
    next_cycle();
    i_req = 1'b0;
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90;
    mid();
    check("wt_rv_i_rvalid", 32'(i_rvalid_3), 32'd1);
    check("wt_rv_i_rdata", i_rdata_3, 32'h0BADF00D);
    check("wt_rv_d_gnt", 32'(d_gnt_3), 32'd0);
    check("wt_rv_mem_req", 32'(mem_req_3), 32'd0);
    next_cycle();
    mid();
    check("wt_d_gnt_c4", 32'(d_gnt_3), 32'd1);
    check("wt_i_gnt_c4", 32'(i_gnt_3), 32'd0);
    check("wt_addr_c4", mem_addr_3, 32'h90);
    next_cycle();
    d_req = 1'b0;
    for (int c = 5; c < 10; c++) begin
      mid();
      check($sformatf("wt_no_i_gnt_c%0d", c), 32'(i_gnt_3), 32'd0);
      check($sformatf("wt_no_i_rvalid_c%0d", c), 32'(i_rvalid_3), 32'd0);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
